si_acc_ctrl: RTL and testbench
==============================

SI_ACC_CTRL -- requirements
Module: si_acc_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the signed operand, accumulator and result width.
REQ-002 SHALL have parameter LEN_W, default 4, meaning the width of the operand-count field.
REQ-003 SHALL have port CLK  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port RST_N  input  1  reset; one clock, asynchronous, active-low.
REQ-005 SHALL have port START  input  1  job request, sampled only in IDLE.
REQ-006 SHALL have port LEN  input  LEN_W  number of operands in the job, latched on accepted START.
REQ-007 SHALL have port IN_VALID  input  1  operand valid.
REQ-008 SHALL have port IN_DATA  input  DATA_W  signed two's-complement operand.
REQ-009 SHALL have port IN_READY  output  1  operand accepted when IN_VALID and IN_READY are both high.
REQ-010 SHALL have port OUT_VALID  output  1  result valid.
REQ-011 SHALL have port OUT_READY  input  1  result consumer ready.
REQ-012 SHALL have port OUT_DATA  output  DATA_W  signed accumulated sum.
REQ-013 SHALL have port OVF  output  1  sticky signed-overflow flag for the current job.
REQ-014 SHALL have port BUSY  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-016 SHALL, in IDLE with START=1 and LEN!=0, latch LEN, clear the accumulator, counter and OVF, and enter ACCUM on the next cycle.
REQ-017 SHALL, in IDLE with START=1 and LEN=0, enter DONE with OUT_DATA=0 and OVF=0.
REQ-018 SHALL ignore START in ACCUM and DONE; LEN and IN_DATA changes there SHALL have no effect on the latched job.
REQ-019 SHALL drive IN_READY=1 only in ACCUM, allowing throughput of one operand per cycle.
REQ-020 SHALL, on each accepted beat, compute acc + IN_DATA through the shared adder and register the result, with a DATA_W-bit result that wraps modulo 2^DATA_W.
REQ-021 SHALL detect overflow when both operands have the same sign and the sum's sign differs, and SHALL then set OVF, which stays set until the next accepted START.
REQ-022 SHALL move from ACCUM to DONE on the accepted beat whose count equals the latched LEN, with OUT_VALID high on the following cycle.
REQ-023 SHALL, in DONE, hold OUT_VALID=1 and keep OUT_DATA and OVF stable until OUT_READY=1, then return to IDLE on the next cycle.
REQ-024 SHALL, when IN_VALID is low in ACCUM, stall with no change to the accumulator or counter, with no timeout.
REQ-025 SHALL require at least one IDLE cycle between jobs, because START is not sampled in DONE.

Reset
REQ-026 SHALL, on RST_N=0 and immediately, clear all outputs and state: state=IDLE; IN_READY, OUT_VALID, OVF and BUSY=0; OUT_DATA, accumulator and counter=0.
REQ-027 SHALL, when reset is asserted mid-job, discard the partial sum and not emit a result after reset release.

Configuration
REQ-028 SHALL, when SI_ACC_SAT_EN is defined, replace the registered sum on overflow with +(2^(DATA_W-1)-1) for positive overflow or -(2^(DATA_W-1)) for negative overflow, and still set OVF.
REQ-029 SHALL, when SI_ACC_SAT_EN is not defined, register the wrapped sum and report OVF only.

Structure
REQ-030 SHALL place the FSM state enum and the default DATA_W and LEN_W constants in the shared package si_pkg.
REQ-031 SHALL instantiate the existing SI_ADD as its sole sub-module, with acc on A, IN_DATA on B and the sum taken from A_ADD_B; no other adder SHALL be inferred.

Verification
REQ-032 SHALL cover: LEN=2, operands 3,5 -> OUT_VALID one cycle after the second beat, OUT_DATA=8, OVF=0.
REQ-033 SHALL cover: LEN=4, operands 13,-1,-1,-2 with IN_VALID gaps -> OUT_DATA=9, with IN_READY high throughout ACCUM.
REQ-034 SHALL cover: LEN=2, operands 125,10 -> OUT_DATA=-121 with OVF=1 without the macro, and OUT_DATA=127 with OVF=1 with SI_ACC_SAT_EN.
REQ-035 SHALL cover: LEN=2, operands -100,-100 -> OUT_DATA=56 with OVF=1 without the macro, and OUT_DATA=-128 with OVF=1 with the macro.
REQ-036 SHALL cover: LEN=0 -> DONE with OUT_DATA=0; then OUT_READY held low for 5 cycles -> OUT_DATA stable, IN_READY=0, and a START pulse during DONE ignored.
REQ-037 SHALL cover: RST_N pulsed low after 1 of 3 beats -> all outputs 0 at once, no OUT_VALID afterwards, and a new job LEN=1 with operand -1 -> OUT_DATA=-1.

Source files
------------

// File: rtl/si_pkg.sv
//------------------------------------------------------------------------------
// Module  : si_pkg
// Brief   : Shared constants and FSM state encoding for the si_* accumulator.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package si_pkg;

    localparam int c_DATA_W = 8;
    localparam int c_LEN_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/si_add.sv
//------------------------------------------------------------------------------
// Module  : si_add
// Brief   : Plain modulo-2^WIDTH adder shared by the accumulator datapath.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module si_add
    import si_pkg::*;
#(
    parameter int WIDTH = c_DATA_W
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] A_ADD_B
);

    assign A_ADD_B = A + B;

endmodule

`default_nettype wire

// File: rtl/si_acc_ctrl.sv
//------------------------------------------------------------------------------
// Module  : si_acc_ctrl
// Brief   : Length-framed signed accumulator with valid/ready operand and
//           result handshakes; SI_ACC_SAT_EN selects saturating accumulation.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module si_acc_ctrl
    import si_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int LEN_W  = c_LEN_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [LEN_W-1:0]  LEN,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              IN_READY,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OVF,
    output logic              BUSY
);

    localparam logic [DATA_W-1:0] c_SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] c_SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t             r_state;
    state_t             w_next;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_inc;
    logic [DATA_W-1:0]  r_acc;
    logic [DATA_W-1:0]  w_sum;
    logic [DATA_W-1:0]  w_acc_d;
    logic               r_ovf;
    logic               w_accept;
    logic               w_beat;
    logic               w_last;
    logic               w_ovf_beat;

    si_add #(.WIDTH(DATA_W)) u_add (
        .A       (r_acc),
        .B       (IN_DATA),
        .A_ADD_B (w_sum)
    );

    assign w_accept   = (r_state == S_IDLE) && START;
    assign w_beat     = (r_state == S_ACCUM) && IN_VALID;
    assign w_cnt_inc  = r_cnt + LEN_W'(1);
    assign w_last     = (w_cnt_inc == r_len);
    // Same-sign operands producing an opposite-sign sum is a signed overflow.
    assign w_ovf_beat = (r_acc[DATA_W-1] == IN_DATA[DATA_W-1]) &&
                        (w_sum[DATA_W-1] != r_acc[DATA_W-1]);

`ifdef SI_ACC_SAT_EN
    assign w_acc_d = !w_ovf_beat      ? w_sum     :
                     r_acc[DATA_W-1]  ? c_SAT_MIN : c_SAT_MAX;
`else
    assign w_acc_d = w_sum;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        BUSY      = 1'b1;
        case (r_state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (START) begin
                    w_next = (LEN == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                IN_READY = 1'b1;
                if (w_beat && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                BUSY   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_len <= '0;
            r_cnt <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_len <= LEN;
            r_cnt <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_beat) begin
            r_acc <= w_acc_d;
            r_cnt <= w_cnt_inc;
            if (w_ovf_beat) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign OUT_DATA = r_acc;
    assign OVF      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_si_acc_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_si_acc_ctrl
// Brief   : Scoreboard bench for si_acc_ctrl; honours SI_ACC_SAT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_si_acc_ctrl;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [3:0]        len;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              ovf;
    logic              busy;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rdy_bad  = 0;

    si_acc_ctrl #(.DATA_W(8), .LEN_W(4)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .START     (start),
        .LEN       (len),
        .IN_VALID  (in_valid),
        .IN_DATA   (in_data),
        .IN_READY  (in_ready),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_DATA  (out_data),
        .OVF       (ovf),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    task automatic start_job(input logic [3:0] l);
        @(negedge clk);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        len   = 4'($urandom);
    endtask

    task automatic beat(input logic signed [7:0] d, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            if (in_ready !== 1'b1) rdy_bad++;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        if (in_ready !== 1'b1) rdy_bad++;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic wait_result(output int waited);
        waited = 0;
        while (out_valid !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Runs a complete job and compares latency, result and return to idle.
    task automatic run_job(input string name, input logic [3:0] l,
                           input logic signed [7:0] ops[$], input int gaps[$],
                           input logic [7:0] exp_data, input logic exp_ovf);
        int   w;
        exp_t e;
        sb.push_back('{exp_data, exp_ovf});
        rdy_bad = 0;
        start_job(l);
        foreach (ops[i]) beat(ops[i], gaps[i]);
        wait_result(w);
        n_checks++;
        if (w !== 0) begin
            n_fail++;
            $display("FAIL %s latency: OUT_VALID after %0d extra cycles, expected 0", name, w);
        end
        e = sb.pop_front();
        n_checks++;
        if (out_data !== e.data || ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL %s result: got data=%0d ovf=%b, expected data=%0d ovf=%b",
                     name, $signed(out_data), ovf, $signed(e.data), e.ovf);
        end
        n_checks++;
        if (rdy_bad !== 0) begin
            n_fail++;
            $display("FAIL %s in_ready: low on %0d ACCUM cycles, expected 0", name, rdy_bad);
        end
        release_result();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle: busy=%b out_valid=%b, expected 0 0", name, busy, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, ovf, busy, out_data} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset: rdy=%b vld=%b ovf=%b busy=%b data=%h, expected all 0",
                     in_ready, out_valid, ovf, busy, out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_job("basic", 4'd2, '{8'sd3, 8'sd5}, '{0, 0}, 8'd8, 1'b0);
    endtask

    task automatic test_gaps();
        run_job("gaps", 4'd4, '{8'sd13, -8'sd1, -8'sd1, -8'sd2}, '{0, 2, 1, 3}, 8'd9, 1'b0);
    endtask

    task automatic test_ovf();
`ifdef SI_ACC_SAT_EN
        run_job("ovf_pos", 4'd2, '{8'sd125, 8'sd10}, '{0, 0}, 8'h7F, 1'b1);
        run_job("ovf_neg", 4'd2, '{-8'sd100, -8'sd100}, '{0, 1}, 8'h80, 1'b1);
`else
        run_job("ovf_pos", 4'd2, '{8'sd125, 8'sd10}, '{0, 0}, 8'h87, 1'b1);
        run_job("ovf_neg", 4'd2, '{-8'sd100, -8'sd100}, '{0, 1}, 8'd56, 1'b1);
`endif
    endtask

    task automatic test_len0_hold();
        int   w;
        int   bad;
        exp_t e;
        sb.push_back('{8'd0, 1'b0});
        start_job(4'd0);
        wait_result(w);
        n_checks++;
        if (w !== 0) begin
            n_fail++;
            $display("FAIL len0 latency: OUT_VALID after %0d extra cycles, expected 0", w);
        end
        e   = sb.pop_front();
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            len   = 4'd2;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== e.data || ovf !== e.ovf ||
                in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL len0 hold cycle %0d: vld=%b data=%h ovf=%b rdy=%b busy=%b, expected 1 %h %b 0 1",
                         c, out_valid, out_data, ovf, in_ready, busy, e.data, e.ovf);
            end
            @(negedge clk);
        end
        start = 1'b0;
        release_result();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL len0 idle: busy=%b out_valid=%b, expected 0 0", busy, out_valid);
        end
    endtask

    task automatic test_mid_reset();
        int late;
        start_job(4'd3);
        beat(8'sd7, 0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, ovf, busy, out_data} !== 12'h000) begin
            n_fail++;
            $display("FAIL midreset async: rdy=%b vld=%b ovf=%b busy=%b data=%h, expected all 0",
                     in_ready, out_valid, ovf, busy, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        late  = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) late++;
        end
        n_checks++;
        if (late !== 0) begin
            n_fail++;
            $display("FAIL midreset residue: %0d cycles with activity, expected 0", late);
        end
        run_job("after_reset", 4'd1, '{-8'sd1}, '{0}, 8'hFF, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_ovf();
        test_len0_hold();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
